mem_access_seq: RTL and testbench
=================================

Name: mem_access_seq

Overview:
- Multi-cycle load/store sequencer between the datapath (address mux, write-data path, IR and MDR consumers) and a word-wide, single-port synchronous BRAM with no byte enables.
- Turns one byte-addressed request plus funct3 into word reads and writes:
  - byte/half loads are lane-selected and sign- or zero-extended;
  - byte/half stores use read-modify-write.
- Reports completion with a one-cycle mem_rdy_o pulse.
- Flags misaligned or illegal requests.

Parameters:
- DATA_WIDTH, 32, word width (fixed 32; others unsupported)
- WORD_ADDR_WIDTH, 10, BRAM word-address bits (1024 words; reset vector word 0x3FF)

Ports:
- clk_i  in  1  clock, rising edge
- reset_i  in  1  asynchronous, active-high reset
- byte_addr_i  in  DATA_WIDTH  byte address; bits [WORD_ADDR_WIDTH+1:2] index the word, upper bits ignored
- funct3_i  in  3  RV32I width/sign code
- wd_i  in  DATA_WIDTH  store data, low bytes significant
- mrd_i  in  1  load request, sampled only in IDLE
- mwr_i  in  1  store request, sampled only in IDLE
- rd_o  out  DATA_WIDTH  extended load result, registered
- mem_rdy_o  out  1  one-cycle completion pulse
- busy_o  out  1  high whenever state != IDLE
- fault_o  out  1  high with mem_rdy_o when the request was rejected
- mem_addr_o  out  WORD_ADDR_WIDTH  BRAM word address, registered at accept
- mem_re_o  out  1  BRAM read enable
- mem_we_o  out  1  BRAM write enable
- mem_wdata_o  out  DATA_WIDTH  BRAM write data
- mem_rdata_i  in  DATA_WIDTH  BRAM read data, valid one cycle after mem_re_o

Behaviour:
- Reset (async, immediate):
  - state = IDLE;
  - rd_o, mem_addr_o and mem_wdata_o = 0;
  - mem_re_o, mem_we_o, mem_rdy_o, fault_o and busy_o = 0.
  - Reset mid-write deasserts mem_we_o at once. No partial-RMW recovery.
- States: IDLE, RD, MERGE, CAPT, WR, DONE.
- IDLE:
  - mwr_i has priority over mrd_i.
  - On an accepted request, latch the word address, byte offset [1:0], funct3 and wd_i.
  - Later changes to these inputs are ignored until the next IDLE.
- Legal codes:
  - loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU;
  - stores: 000 SB, 001 SH, 010 SW.
- Fault conditions:
  - any other code;
  - halfword with offset[0]=1;
  - word with offset != 0.
  - Action: IDLE -> DONE with fault_o=1. No BRAM access; rd_o unchanged.
- Load path: IDLE -> RD (mem_re_o=1) -> CAPT -> DONE.
  - In CAPT, take byte lane offset*8 or half lane offset[1]*16 from mem_rdata_i.
  - Sign-extend for 000/001; zero-extend for 100/101.
  - Register rd_o on the CAPT->DONE edge.
- SW path: IDLE -> WR (mem_we_o=1, mem_wdata_o=wd) -> DONE.
- SB/SH path: IDLE -> RD -> MERGE -> WR -> DONE.
  - In MERGE, register the merged word: read data with the target lane replaced by wd[7:0] or wd[15:0].
  - In WR, write the merged word.
- DONE: mem_rdy_o=1 for exactly one cycle, then IDLE.
- Latency from accept edge to mem_rdy_o high:
  - fault: 1 cycle;
  - SW: 2 cycles;
  - load: 3 cycles;
  - SB/SH: 4 cycles.
- Requests while busy are dropped. No queueing.
- A request held high through DONE is re-accepted on the first IDLE edge after DONE.
- rd_o holds its value until the next successful load. Stores do not change it.
- mem_re_o and mem_we_o are never high together.
- Address wrap: byte address 0x1000 maps to word 0.

Decomposition:
- Package mem_access_pkg holds:
  - state enum (3-bit);
  - funct3 constants F3_B/F3_H/F3_W/F3_BU/F3_HU;
  - lane-width localparams.
- One combinational sub-module, ld_st_align. It provides:
  - load lane select plus sign/zero extend;
  - store merge;
  - misalign/illegal check.
- Inputs: offset, funct3, rdata, wd.
- Outputs: load_val, merged, fault.

Test Plan:
- Word 0x3FF preloaded 0x8899AABB; LW at byte 0xFFC -> rd_o=0x8899AABB, mem_rdy_o 3 cycles after accept, busy_o high for 3 cycles.
- Same word:
  - LB at 0xFFD -> 0xFFFFFFAA;
  - LBU at 0xFFD -> 0x000000AA;
  - LH at 0xFFE -> 0xFFFF8899;
  - LHU at 0xFFE -> 0x00008899.
- Word 5 = 0x11223344; SB wd=0xDEADBEEF at byte 0x16 -> word 5 = 0x11EF3344. SH wd=0x0000CAFE at 0x14 -> 0x11EFCAFE. Each store shows mem_rdy_o 4 cycles after accept and exactly one mem_we_o cycle.
- LW at byte 0x6, and separately funct3=011 -> fault_o=1 with mem_rdy_o 1 cycle after accept, no mem_re_o/mem_we_o, rd_o unchanged.
- mrd_i=mwr_i=1 with SW wd=0x12345678 at 0x8 -> write performed, word 2 = 0x12345678. A second mrd_i pulse while busy -> ignored.
- Assert reset_i during WR of an SB -> mem_we_o low in the same cycle, all outputs 0, state IDLE. A new LW completes normally after release.

Source files
------------

// File: rtl/mem_access_seq_pkg.sv
// +----------------------------------------------------------------------+
// | mem_access_pkg                                                       |
// | Shared types and constants for the load/store sequencer.             |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

package mem_access_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD    = 3'd1,
    S_MERGE = 3'd2,
    S_CAPT  = 3'd3,
    S_WR    = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int c_byte_bits = 8;
  localparam int c_half_bits = 16;

endpackage

`default_nettype wire

// File: rtl/mem_access_seq_if.sv
// +----------------------------------------------------------------------+
// | mem_access_seq_if                                                    |
// | Datapath request/response and BRAM port bundle for the sequencer.    |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

interface mem_access_seq_if #(
  parameter int DATA_WIDTH      = 32,
  parameter int WORD_ADDR_WIDTH = 10
);

  logic [DATA_WIDTH-1:0]      byte_addr_i;
  logic [2:0]                 funct3_i;
  logic [DATA_WIDTH-1:0]      wd_i;
  logic                       mrd_i;
  logic                       mwr_i;
  logic [DATA_WIDTH-1:0]      rd_o;
  logic                       mem_rdy_o;
  logic                       busy_o;
  logic                       fault_o;
  logic [WORD_ADDR_WIDTH-1:0] mem_addr_o;
  logic                       mem_re_o;
  logic                       mem_we_o;
  logic [DATA_WIDTH-1:0]      mem_wdata_o;
  logic [DATA_WIDTH-1:0]      mem_rdata_i;

  modport slave (
    input  byte_addr_i, funct3_i, wd_i, mrd_i, mwr_i, mem_rdata_i,
    output rd_o, mem_rdy_o, busy_o, fault_o,
    output mem_addr_o, mem_re_o, mem_we_o, mem_wdata_o
  );

  modport master (
    output byte_addr_i, funct3_i, wd_i, mrd_i, mwr_i, mem_rdata_i,
    input  rd_o, mem_rdy_o, busy_o, fault_o,
    input  mem_addr_o, mem_re_o, mem_we_o, mem_wdata_o
  );

endinterface

`default_nettype wire

// File: rtl/mem_access_seq_ld_st_align.sv
// +----------------------------------------------------------------------+
// | ld_st_align                                                          |
// | Load lane extract/extend, store lane merge, alignment/legality check.|
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module ld_st_align
  import mem_access_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [1:0]            offset,
  input  logic [2:0]            funct3,
  input  logic                  is_store,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [DATA_WIDTH-1:0] wd,
  output logic [DATA_WIDTH-1:0] load_val,
  output logic [DATA_WIDTH-1:0] merged,
  output logic                  fault
);

  logic [c_byte_bits-1:0] w_byte;
  logic [c_half_bits-1:0] w_half;
  logic                   w_legal;

  always_comb begin
    w_byte = rdata[{offset, 3'b000} +: c_byte_bits];
    w_half = rdata[{offset[1], 4'b0000} +: c_half_bits];

    load_val = '0;
    case (funct3)
      F3_B:    load_val = {{(DATA_WIDTH-c_byte_bits){w_byte[c_byte_bits-1]}}, w_byte};
      F3_H:    load_val = {{(DATA_WIDTH-c_half_bits){w_half[c_half_bits-1]}}, w_half};
      F3_W:    load_val = rdata;
      F3_BU:   load_val = {{(DATA_WIDTH-c_byte_bits){1'b0}}, w_byte};
      F3_HU:   load_val = {{(DATA_WIDTH-c_half_bits){1'b0}}, w_half};
      default: load_val = '0;
    endcase
  end

  // Only the addressed lane is replaced; the rest of the read word is written back unchanged.
  always_comb begin
    merged = rdata;
    case (funct3[1:0])
      2'b00:   merged[{offset, 3'b000} +: c_byte_bits]    = wd[c_byte_bits-1:0];
      2'b01:   merged[{offset[1], 4'b0000} +: c_half_bits] = wd[c_half_bits-1:0];
      default: merged = wd;
    endcase
  end

  always_comb begin
    if (is_store) begin
      w_legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
    end else begin
      w_legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
                (funct3 == F3_BU) || (funct3 == F3_HU);
    end
    fault = !w_legal ||
            ((funct3[1:0] == 2'b01) && offset[0]) ||
            ((funct3[1:0] == 2'b10) && (offset != 2'b00));
  end

endmodule

`default_nettype wire

// File: rtl/mem_access_seq.sv
// +----------------------------------------------------------------------+
// | mem_access_seq                                                       |
// | Multi-cycle load/store sequencer in front of a word-wide BRAM.       |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module mem_access_seq
  import mem_access_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int WORD_ADDR_WIDTH = 10
) (
  input  logic            clk_i,
  input  logic            reset_i,
  mem_access_seq_if.slave bus
);

  state_t                     r_state;
  state_t                     w_state_nxt;

  logic [WORD_ADDR_WIDTH-1:0] r_addr;
  logic [1:0]                 r_offset;
  logic [2:0]                 r_funct3;
  logic                       r_is_store;
  logic                       r_fault;
  logic [DATA_WIDTH-1:0]      r_wd;
  logic [DATA_WIDTH-1:0]      r_wdata;
  logic [DATA_WIDTH-1:0]      r_rd;

  logic                       w_req;
  logic [1:0]                 w_offset;
  logic [2:0]                 w_funct3;
  logic                       w_is_store;
  logic                       w_fault;
  logic [DATA_WIDTH-1:0]      w_load_val;
  logic [DATA_WIDTH-1:0]      w_merged;
  logic                       w_unused_addr;

  assign w_req         = bus.mrd_i | bus.mwr_i;
  assign w_unused_addr = &{1'b0, bus.byte_addr_i[DATA_WIDTH-1:WORD_ADDR_WIDTH+2]};

  // The checker sees the live request in IDLE (to decide the path) and the latched one afterwards.
  always_comb begin
    w_offset   = r_offset;
    w_funct3   = r_funct3;
    w_is_store = r_is_store;
    if (r_state == S_IDLE) begin
      w_offset   = bus.byte_addr_i[1:0];
      w_funct3   = bus.funct3_i;
      w_is_store = bus.mwr_i;
    end
  end

  ld_st_align #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_align (
    .offset   (w_offset),
    .funct3   (w_funct3),
    .is_store (w_is_store),
    .rdata    (bus.mem_rdata_i),
    .wd       (r_wd),
    .load_val (w_load_val),
    .merged   (w_merged),
    .fault    (w_fault)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          if (w_fault) begin
            w_state_nxt = S_DONE;
          end else if (bus.mwr_i && (bus.funct3_i == F3_W)) begin
            w_state_nxt = S_WR;
          end else begin
            w_state_nxt = S_RD;
          end
        end
      end
      S_RD:    w_state_nxt = r_is_store ? S_MERGE : S_CAPT;
      S_MERGE: w_state_nxt = S_WR;
      S_CAPT:  w_state_nxt = S_DONE;
      S_WR:    w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_addr     <= '0;
      r_offset   <= '0;
      r_funct3   <= '0;
      r_is_store <= 1'b0;
      r_fault    <= 1'b0;
      r_wd       <= '0;
      r_wdata    <= '0;
      r_rd       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_addr     <= bus.byte_addr_i[WORD_ADDR_WIDTH+1:2];
            r_offset   <= bus.byte_addr_i[1:0];
            r_funct3   <= bus.funct3_i;
            r_is_store <= bus.mwr_i;
            r_fault    <= w_fault;
            r_wd       <= bus.wd_i;
            if (bus.mwr_i && !w_fault) begin
              r_wdata <= bus.wd_i;
            end
          end
        end
        S_MERGE: r_wdata <= w_merged;
        S_CAPT:  r_rd    <= w_load_val;
        default: ;
      endcase
    end
  end

  // Strobes decode straight from the state register so an async reset drops them immediately.
  assign bus.mem_re_o    = (r_state == S_RD);
  assign bus.mem_we_o    = (r_state == S_WR);
  assign bus.mem_rdy_o   = (r_state == S_DONE);
  assign bus.fault_o     = (r_state == S_DONE) && r_fault;
  assign bus.busy_o      = (r_state != S_IDLE);
  assign bus.mem_addr_o  = r_addr;
  assign bus.mem_wdata_o = r_wdata;
  assign bus.rd_o        = r_rd;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_seq.sv
// +----------------------------------------------------------------------+
// | tb_mem_access_seq                                                    |
// | Self-checking bench: BRAM model plus byte-level reference model.     |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_mem_access_seq;

  localparam int DW  = 32;
  localparam int WAW = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_access_seq_if #(.DATA_WIDTH(DW), .WORD_ADDR_WIDTH(WAW)) bus ();

  mem_access_seq #(.DATA_WIDTH(DW), .WORD_ADDR_WIDTH(WAW)) dut (
    .clk_i   (clk),
    .reset_i (rst),
    .bus     (bus)
  );

  logic [31:0] bram    [0:1023];
  logic [31:0] ref_mem [0:1023];
  logic [31:0] ref_rd;
  int errors = 0;
  int checks = 0;

  always @(posedge clk) begin
    if (bus.mem_we_o) bram[bus.mem_addr_o] <= bus.mem_wdata_o;
    if (bus.mem_re_o) bus.mem_rdata_i <= bram[bus.mem_addr_o];
  end

  // ---------------- reference model (byte-level arithmetic) ----------------
  function automatic int ref_size(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit ref_fault(input bit st, input logic [2:0] f3, input logic [1:0] off);
    bit legal;
    if (st) legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
    else    legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    if (!legal) return 1'b1;
    return (int'(off) % ref_size(f3)) != 0;
  endfunction

  function automatic int ref_lat(input bit st, input logic [2:0] f3, input logic [1:0] off);
    if (ref_fault(st, f3, off)) return 1;
    if (!st) return 3;
    return (f3 == 3'd2) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [1:0] off, input logic [2:0] f3);
    logic [31:0] v;
    logic [31:0] mask;
    int sz;
    sz = ref_size(f3);
    v  = word >> (8 * int'(off));
    if (sz < 4) begin
      mask = (32'd1 << (8 * sz)) - 32'd1;
      v    = v & mask;
      if (!f3[2] && v[8*sz-1]) v = v | ~mask;
    end
    return v;
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] word, input logic [1:0] off,
                                            input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] w;
    w = word;
    for (int i = 0; i < ref_size(f3); i++) w[8*(int'(off)+i) +: 8] = wd[8*i +: 8];
    return w;
  endfunction

  // Applies one request and records what the DUT did; comparisons are made by the callers.
  task automatic run_req(input bit st, input bit both, input logic [31:0] a, input logic [2:0] f3,
                         input logic [31:0] w, input bit poke,
                         output int lat, output int n_re, output int n_we, output int n_busy,
                         output bit saw_fault, output bit overlap);
    int guard;
    guard = 0;
    @(negedge clk);
    while (bus.busy_o && guard < 20) begin @(negedge clk); guard++; end
    bus.byte_addr_i = a; bus.funct3_i = f3; bus.wd_i = w;
    bus.mwr_i = st; bus.mrd_i = !st || both;
    @(posedge clk); #1;
    bus.mrd_i = 1'b0; bus.mwr_i = 1'b0;
    bus.byte_addr_i = $urandom; bus.funct3_i = 3'($urandom); bus.wd_i = $urandom;
    lat = 1; n_re = 0; n_we = 0; n_busy = 0; saw_fault = 1'b0; overlap = 1'b0;
    while (1) begin
      if (bus.mem_re_o) n_re++;
      if (bus.mem_we_o) n_we++;
      if (bus.busy_o) n_busy++;
      if (bus.mem_re_o && bus.mem_we_o) overlap = 1'b1;
      bus.mrd_i = poke && (lat == 1);
      if (bus.mem_rdy_o) begin saw_fault = bus.fault_o; break; end
      if (lat >= 12) begin lat = -1; break; end
      @(posedge clk); #1; lat++;
    end
    bus.mrd_i = 1'b0;
    @(posedge clk); #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.rd_o !== 32'h0) begin errors++; $display("FAIL reset_rd: got %h want 0", bus.rd_o); end
    checks++; if (bus.mem_addr_o !== 10'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", bus.mem_addr_o); end
    checks++; if (bus.mem_wdata_o !== 32'h0) begin errors++; $display("FAIL reset_wdata: got %h want 0", bus.mem_wdata_o); end
    checks++; if ({bus.mem_re_o, bus.mem_we_o, bus.mem_rdy_o, bus.fault_o, bus.busy_o} !== 5'b0) begin
      errors++; $display("FAIL reset_strobes: got %b want 00000",
                         {bus.mem_re_o, bus.mem_we_o, bus.mem_rdy_o, bus.fault_o, bus.busy_o});
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL reset_idle_busy: got %b want 0", bus.busy_o); end
  endtask

  task automatic test_loads;
    logic [31:0] addrs [5] = '{32'hFFC, 32'hFFD, 32'hFFD, 32'hFFE, 32'hFFE};
    logic [2:0]  f3s   [5] = '{3'b010, 3'b000, 3'b100, 3'b001, 3'b101};
    logic [31:0] exps  [5] = '{32'h8899AABB, 32'hFFFFFFAA, 32'h000000AA, 32'hFFFF8899, 32'h00008899};
    int lat, n_re, n_we, n_busy;
    bit flt, ovl;
    for (int i = 0; i < 5; i++) begin
      run_req(1'b0, 1'b0, addrs[i], f3s[i], 32'h0, 1'b0, lat, n_re, n_we, n_busy, flt, ovl);
      ref_rd = exps[i];
      checks++; if (bus.rd_o !== exps[i]) begin errors++; $display("FAIL load_%0d_value: got %h want %h", i, bus.rd_o, exps[i]); end
      checks++; if (lat !== 3 || flt !== 1'b0 || n_re !== 1) begin
        errors++; $display("FAIL load_%0d_timing: lat=%0d fault=%b re=%0d want lat=3 fault=0 re=1", i, lat, flt, n_re);
      end
      if (i == 0) begin
        checks++; if (n_busy !== 3) begin errors++; $display("FAIL lw_busy_cycles: got %0d want 3", n_busy); end
      end
    end
  endtask

  task automatic test_stores;
    int lat, n_re, n_we, n_busy;
    bit flt, ovl;
    run_req(1'b1, 1'b0, 32'h16, 3'b000, 32'hDEADBEEF, 1'b0, lat, n_re, n_we, n_busy, flt, ovl);
    ref_mem[5] = 32'h11EF3344;
    checks++; if (bram[5] !== 32'h11EF3344) begin errors++; $display("FAIL sb_word: got %h want 11ef3344", bram[5]); end
    checks++; if (lat !== 4 || n_we !== 1 || ovl) begin
      errors++; $display("FAIL sb_timing: lat=%0d we=%0d overlap=%b want lat=4 we=1 overlap=0", lat, n_we, ovl);
    end
    run_req(1'b1, 1'b0, 32'h14, 3'b001, 32'h0000CAFE, 1'b0, lat, n_re, n_we, n_busy, flt, ovl);
    ref_mem[5] = 32'h11EFCAFE;
    checks++; if (bram[5] !== 32'h11EFCAFE) begin errors++; $display("FAIL sh_word: got %h want 11efcafe", bram[5]); end
    checks++; if (lat !== 4 || n_we !== 1 || ovl) begin
      errors++; $display("FAIL sh_timing: lat=%0d we=%0d overlap=%b want lat=4 we=1 overlap=0", lat, n_we, ovl);
    end
    checks++; if (bus.rd_o !== ref_rd) begin errors++; $display("FAIL store_keeps_rd: got %h want %h", bus.rd_o, ref_rd); end
  endtask

  task automatic test_faults;
    int lat, n_re, n_we, n_busy;
    bit flt, ovl;
    run_req(1'b0, 1'b0, 32'h6, 3'b010, 32'h0, 1'b0, lat, n_re, n_we, n_busy, flt, ovl);
    checks++; if (flt !== 1'b1 || lat !== 1 || n_re !== 0 || n_we !== 0) begin
      errors++; $display("FAIL misaligned_lw: fault=%b lat=%0d re=%0d we=%0d want 1/1/0/0", flt, lat, n_re, n_we);
    end
    checks++; if (bus.rd_o !== ref_rd) begin errors++; $display("FAIL misaligned_rd: got %h want %h", bus.rd_o, ref_rd); end
    run_req(1'b0, 1'b0, 32'h0, 3'b011, 32'h0, 1'b0, lat, n_re, n_we, n_busy, flt, ovl);
    checks++; if (flt !== 1'b1 || lat !== 1 || n_re !== 0 || n_we !== 0) begin
      errors++; $display("FAIL illegal_f3: fault=%b lat=%0d re=%0d we=%0d want 1/1/0/0", flt, lat, n_re, n_we);
    end
    checks++; if (bus.rd_o !== ref_rd) begin errors++; $display("FAIL illegal_rd: got %h want %h", bus.rd_o, ref_rd); end
  endtask

  task automatic test_priority_and_drop;
    int lat, n_re, n_we, n_busy, stray;
    bit flt, ovl;
    run_req(1'b1, 1'b1, 32'h8, 3'b010, 32'h12345678, 1'b1, lat, n_re, n_we, n_busy, flt, ovl);
    ref_mem[2] = 32'h12345678;
    checks++; if (bram[2] !== 32'h12345678) begin errors++; $display("FAIL both_req_word: got %h want 12345678", bram[2]); end
    checks++; if (lat !== 2 || n_re !== 0 || n_we !== 1) begin
      errors++; $display("FAIL both_req_sw: lat=%0d re=%0d we=%0d want 2/0/1", lat, n_re, n_we);
    end
    stray = 0;
    repeat (4) begin
      if (bus.busy_o || bus.mem_re_o) stray++;
      @(posedge clk); #1;
    end
    checks++; if (stray !== 0) begin errors++; $display("FAIL busy_drop: got %0d stray busy cycles want 0", stray); end
  endtask

  task automatic test_hold_reaccept;
    int first, second;
    first = -1; second = -1;
    @(negedge clk);
    bus.byte_addr_i = 32'hFFC; bus.funct3_i = 3'b010; bus.mrd_i = 1'b1; bus.mwr_i = 1'b0;
    @(posedge clk); #1;
    for (int k = 1; k <= 12; k++) begin
      if (bus.mem_rdy_o) begin
        if (first < 0) first = k;
        else if (second < 0) begin second = k; bus.mrd_i = 1'b0; end
      end
      @(posedge clk); #1;
    end
    bus.mrd_i = 1'b0;
    ref_rd = ref_mem[10'h3FF];
    checks++; if (first !== 3 || second !== 7) begin
      errors++; $display("FAIL hold_reaccept: rdy at %0d,%0d want 3,7", first, second);
    end
    checks++; if (bus.rd_o !== ref_rd) begin errors++; $display("FAIL hold_rd: got %h want %h", bus.rd_o, ref_rd); end
  endtask

  task automatic test_random;
    logic [2:0] legal_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    int lat, n_re, n_we, n_busy, idx;
    bit flt, ovl, st, ef;
    logic [2:0]  f3;
    logic [1:0]  off;
    logic [31:0] a, wd;
    for (int n = 0; n < 40; n++) begin
      idx = $urandom_range(0, 7);
      st  = 1'($urandom_range(0, 1));
      f3  = ($urandom_range(0, 3) != 0) ? legal_f3[$urandom_range(0, st ? 2 : 4)] : 3'($urandom);
      off = 2'($urandom);
      a   = ($urandom & 32'hFFFFF000) | (idx << 2) | 32'(off);
      wd  = $urandom;
      ef  = ref_fault(st, f3, off);
      run_req(st, 1'b0, a, f3, wd, 1'b0, lat, n_re, n_we, n_busy, flt, ovl);
      if (!ef) begin
        if (st) ref_mem[idx] = ref_store(ref_mem[idx], off, f3, wd);
        else    ref_rd = ref_load(ref_mem[idx], off, f3);
      end
      checks++; if (flt !== ef || lat !== ref_lat(st, f3, off) || ovl) begin
        errors++; $display("FAIL rand_%0d_ctl: fault=%b lat=%0d ovl=%b want fault=%b lat=%0d ovl=0",
                           n, flt, lat, ovl, ef, ref_lat(st, f3, off));
      end
      checks++; if (bus.rd_o !== ref_rd || bram[idx] !== ref_mem[idx]) begin
        errors++; $display("FAIL rand_%0d_data: rd=%h word=%h want rd=%h word=%h",
                           n, bus.rd_o, bram[idx], ref_rd, ref_mem[idx]);
      end
    end
  endtask

  task automatic test_reset_mid_write;
    int guard, lat, n_re, n_we, n_busy;
    bit flt, ovl;
    @(negedge clk);
    while (bus.busy_o) @(negedge clk);
    bus.byte_addr_i = 32'h1D; bus.funct3_i = 3'b000; bus.wd_i = 32'h000000A5;
    bus.mwr_i = 1'b1; bus.mrd_i = 1'b0;
    @(posedge clk); #1;
    bus.mwr_i = 1'b0;
    guard = 0;
    while (!bus.mem_we_o && guard < 10) begin @(posedge clk); #1; guard++; end
    checks++; if (bus.mem_we_o !== 1'b1) begin errors++; $display("FAIL rst_reach_wr: we=%b want 1", bus.mem_we_o); end
    #2 rst = 1'b1;
    #1;
    checks++; if ({bus.mem_re_o, bus.mem_we_o, bus.mem_rdy_o, bus.fault_o, bus.busy_o} !== 5'b0 ||
                  bus.rd_o !== 32'h0 || bus.mem_addr_o !== 10'h0 || bus.mem_wdata_o !== 32'h0) begin
      errors++; $display("FAIL rst_mid_write: strobes=%b rd=%h addr=%h wdata=%h want all 0",
                         {bus.mem_re_o, bus.mem_we_o, bus.mem_rdy_o, bus.fault_o, bus.busy_o},
                         bus.rd_o, bus.mem_addr_o, bus.mem_wdata_o);
    end
    @(negedge clk); rst = 1'b0;
    ref_rd = 32'h0;
    checks++; if (bram[7] !== ref_mem[7]) begin errors++; $display("FAIL rst_no_write: got %h want %h", bram[7], ref_mem[7]); end
    run_req(1'b0, 1'b0, 32'h1C, 3'b010, 32'h0, 1'b0, lat, n_re, n_we, n_busy, flt, ovl);
    ref_rd = ref_mem[7];
    checks++; if (bus.rd_o !== ref_rd || lat !== 3 || flt) begin
      errors++; $display("FAIL post_rst_lw: rd=%h lat=%0d fault=%b want rd=%h lat=3 fault=0", bus.rd_o, lat, flt, ref_rd);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.byte_addr_i = '0; bus.funct3_i = '0; bus.wd_i = '0;
    bus.mrd_i = 1'b0; bus.mwr_i = 1'b0;
    for (int i = 0; i < 1024; i++) bram[i] = $urandom;
    bram[10'h3FF] = 32'h8899AABB;
    bram[5]       = 32'h11223344;
    for (int i = 0; i < 1024; i++) ref_mem[i] = bram[i];
    ref_rd = 32'h0;

    test_reset;
    test_loads;
    test_stores;
    test_faults;
    test_priority_and_drop;
    test_hold_reaccept;
    test_random;
    test_reset_mid_write;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
